ex_stage_reg: RTL and testbench
===============================

Name: ex_stage_reg

Overview:
- Execute stage and EX/MEM pipeline register of the 5-stage MIPS pipeline.
- Consumes the ID/EX register outputs: control bits, PC+4, register data, sign-extended immediate and the rt/rd fields.
- Performs ALU-control decode, the ALU operation, branch-target add and destination select.
- Registers the results toward the MEM stage, with stall (hold) and flush (bubble) control.

Parameters:
- DATA_W, 32, datapath width of operands, results and PC.
- REG_AW, 5, register-file address width.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rstn  in  1  asynchronous active-low reset.
- i_stall  in  1  hold all outputs for this cycle.
- i_flush  in  1  insert bubble: clear registered control bits.
- i_MemtoReg, i_MemWrite, i_MemRead, i_Branch, i_ALUSrc, i_RegDst, i_RegWrite  in  1 each  control bits from ID/EX.
- i_ALUOp  in  2  ALU operation class.
- i_PCplus4  in  DATA_W  PC+4 of the instruction.
- i_Rdata1, i_Rdata2  in  DATA_W  rs / rt register values.
- i_signextImmediate  in  DATA_W  sign-extended immediate; bits [5:0] carry funct.
- i_Rs  in  REG_AW  rs field, used only by forwarding.
- i_RegDst1  in  REG_AW  rt field.
- i_RegDst2  in  REG_AW  rd field.
- i_MemWb_RegWrite  in  1  MEM/WB write enable, forwarding source.
- i_MemWb_WriteReg  in  REG_AW  MEM/WB destination register.
- i_MemWb_Data  in  DATA_W  MEM/WB write-back data.
- o_MemtoReg, o_MemWrite, o_MemRead, o_Branch, o_RegWrite  out  1 each  registered control bits.
- o_Zero  out  1  registered ALU-result-equals-zero flag.
- o_ALUResult  out  DATA_W  registered ALU result.
- o_BranchTarget  out  DATA_W  registered PC+4 + (imm<<2).
- o_StoreData  out  DATA_W  registered store data (rt value after forwarding).
- o_WriteReg  out  REG_AW  registered destination register.

Behaviour:
- Reset: i_rstn low asynchronously clears every output to 0, including all control bits and all data outputs.
- Latency: one cycle. Inputs sampled on rising i_clk appear on outputs after that edge.
- ALU control:
  - ALUOp 00 -> add.
  - ALUOp 01 -> sub.
  - ALUOp 10 -> decode funct: 100000 add, 100010 sub, 100100 and, 100101 or, 100111 nor, 101010 slt (signed). Any other funct -> add.
  - ALUOp 11 -> add.
- Operand A = rs value.
- Operand B = i_ALUSrc ? immediate : rt value.
- Arithmetic wraps modulo 2^DATA_W; no overflow trap.
- slt result is 1 or 0, zero-extended.
- o_Zero = (ALU result == 0).
- Branch target = i_PCplus4 + {imm[DATA_W-3:0],2'b00}, wrap-around allowed.
- o_WriteReg = i_RegDst ? i_RegDst2 : i_RegDst1.
- o_StoreData = rt value after forwarding, not the ALU B operand.
- Stall: i_stall=1 -> all outputs hold their previous values.
- Flush: i_flush=1 -> o_MemtoReg, o_MemWrite, o_MemRead, o_Branch, o_RegWrite load 0. Data outputs load normally (don't-care).
- Simultaneous stall and flush: flush wins.
- Reset mid-stall: reset wins, and the outputs are cleared.

Optional Feature:
- FORWARDING_EN defined: rs and rt values are selected by priority:
  - EX/MEM first: own o_RegWrite=1, o_WriteReg!=0 and o_WriteReg matches -> use o_ALUResult.
  - Then MEM/WB: i_MemWb_RegWrite=1, i_MemWb_WriteReg!=0 and it matches -> use i_MemWb_Data.
  - Otherwise the i_Rdata1 / i_Rdata2 value.
  - Register 0 is never forwarded.
- FORWARDING_EN undefined: i_Rdata1 / i_Rdata2 are used directly. i_Rs and the i_MemWb_* ports stay in the port list but are ignored.

Test Plan:
- Reset: assert i_rstn=0 mid-run with i_stall=1 -> all outputs 0 immediately, before any clock edge.
- R-type sub: ALUOp=10, funct=100010, Rdata1=5, Rdata2=5, RegDst=1, rd=9 -> next cycle ALUResult=0, Zero=1, WriteReg=9.
- lw: ALUOp=00, ALUSrc=1, Rdata1=0x1000, imm=0xFFFFFFFC, rt=4, MemRead=1 -> ALUResult=0x00000FFC, WriteReg=4, o_MemRead=1.
- Branch: PCplus4=0x40, imm=0xFFFFFFFF -> BranchTarget=0x3C. slt check: Rdata1=0xFFFFFFFF vs Rdata2=1 -> ALUResult=1.
- Stall/flush: load RegWrite=1 and result 7, then stall 2 cycles with changing inputs -> outputs hold 7. Then stall=1 and flush=1 together -> control bits 0.
- FORWARDING_EN build: add writes r3=10. Next instruction add r5=r3+r3 with stale Rdata1=Rdata2=0 -> ALUResult=20. Repeat with destination r0 -> no forward, ALUResult=0.

Source files
------------

// File: rtl/ex_stage_reg.sv
// ex_stage_reg: MIPS execute stage plus EX/MEM pipeline register.
//
// Decodes ALU control from ALUOp/funct, runs the ALU, adds the branch
// target, picks the destination register and registers everything toward
// MEM with one cycle of latency.
//
// Ports:
//   i_clk, i_rstn        clock (rising) and asynchronous active-low reset
//   i_stall, i_flush     hold all outputs / clear registered control bits
//   i_MemtoReg .. i_ALUOp ID/EX control bits
//   i_PCplus4, i_Rdata1, i_Rdata2, i_signextImmediate  ID/EX datapath
//   i_Rs, i_RegDst1, i_RegDst2  rs / rt / rd register fields
//   i_MemWb_*            MEM/WB write-back, used as a forwarding source
//   o_*                  registered EX/MEM controls, flags and data
//
// Optional feature (macro FORWARDING_EN): when defined, rs/rt operands are
// forwarded from EX/MEM (this register) first, then from MEM/WB. When
// undefined, i_Rs and i_MemWb_* are ignored.

module ex_stage_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_stall,
  input  logic              i_flush,
  input  logic              i_MemtoReg,
  input  logic              i_MemWrite,
  input  logic              i_MemRead,
  input  logic              i_Branch,
  input  logic              i_ALUSrc,
  input  logic              i_RegDst,
  input  logic              i_RegWrite,
  input  logic [1:0]        i_ALUOp,
  input  logic [DATA_W-1:0] i_PCplus4,
  input  logic [DATA_W-1:0] i_Rdata1,
  input  logic [DATA_W-1:0] i_Rdata2,
  input  logic [DATA_W-1:0] i_signextImmediate,
  input  logic [REG_AW-1:0] i_Rs,
  input  logic [REG_AW-1:0] i_RegDst1,
  input  logic [REG_AW-1:0] i_RegDst2,
  input  logic              i_MemWb_RegWrite,
  input  logic [REG_AW-1:0] i_MemWb_WriteReg,
  input  logic [DATA_W-1:0] i_MemWb_Data,
  output logic              o_MemtoReg,
  output logic              o_MemWrite,
  output logic              o_MemRead,
  output logic              o_Branch,
  output logic              o_RegWrite,
  output logic              o_Zero,
  output logic [DATA_W-1:0] o_ALUResult,
  output logic [DATA_W-1:0] o_BranchTarget,
  output logic [DATA_W-1:0] o_StoreData,
  output logic [REG_AW-1:0] o_WriteReg
);

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_NOR,
    ALU_SLT
  } alu_op_e;

  // Pipeline register state
  logic              mem_to_reg_q, mem_to_reg_d;
  logic              mem_write_q,  mem_write_d;
  logic              mem_read_q,   mem_read_d;
  logic              branch_q,     branch_d;
  logic              reg_write_q,  reg_write_d;
  logic              zero_q,       zero_d;
  logic [DATA_W-1:0] alu_q,        alu_d;
  logic [DATA_W-1:0] target_q,     target_d;
  logic [DATA_W-1:0] store_q,      store_d;
  logic [REG_AW-1:0] wr_q,         wr_d;

  logic              load_c;
  alu_op_e           alu_op_c;
  logic [DATA_W-1:0] rs_val_c;
  logic [DATA_W-1:0] rt_val_c;
  logic [DATA_W-1:0] op_b_c;

  // Operand selection (forwarding when enabled)
`ifdef FORWARDING_EN
  always_comb begin
    rs_val_c = i_Rdata1;
    rt_val_c = i_Rdata2;
    if (reg_write_q && (wr_q != '0) && (wr_q == i_Rs)) begin
      rs_val_c = alu_q;
    end else if (i_MemWb_RegWrite && (i_MemWb_WriteReg != '0) &&
                 (i_MemWb_WriteReg == i_Rs)) begin
      rs_val_c = i_MemWb_Data;
    end
    if (reg_write_q && (wr_q != '0) && (wr_q == i_RegDst1)) begin
      rt_val_c = alu_q;
    end else if (i_MemWb_RegWrite && (i_MemWb_WriteReg != '0) &&
                 (i_MemWb_WriteReg == i_RegDst1)) begin
      rt_val_c = i_MemWb_Data;
    end
  end
`else
  logic unused_fwd_c;
  assign unused_fwd_c = ^{i_Rs, i_MemWb_RegWrite, i_MemWb_WriteReg, i_MemWb_Data};

  always_comb begin
    rs_val_c = i_Rdata1;
    rt_val_c = i_Rdata2;
  end
`endif

  // ALU control decode
  always_comb begin
    alu_op_c = ALU_ADD;
    case (i_ALUOp)
      2'b01: alu_op_c = ALU_SUB;
      2'b10: begin
        case (i_signextImmediate[5:0])
          FUNCT_ADD: alu_op_c = ALU_ADD;
          FUNCT_SUB: alu_op_c = ALU_SUB;
          FUNCT_AND: alu_op_c = ALU_AND;
          FUNCT_OR:  alu_op_c = ALU_OR;
          FUNCT_NOR: alu_op_c = ALU_NOR;
          FUNCT_SLT: alu_op_c = ALU_SLT;
          default:   alu_op_c = ALU_ADD;
        endcase
      end
      default: alu_op_c = ALU_ADD;
    endcase
  end

  // ALU, branch target, destination select and next-state
  always_comb begin
    op_b_c = i_ALUSrc ? i_signextImmediate : rt_val_c;

    alu_d = rs_val_c + op_b_c;
    case (alu_op_c)
      ALU_SUB: alu_d = rs_val_c - op_b_c;
      ALU_AND: alu_d = rs_val_c & op_b_c;
      ALU_OR:  alu_d = rs_val_c | op_b_c;
      ALU_NOR: alu_d = ~(rs_val_c | op_b_c);
      ALU_SLT: alu_d = DATA_W'($signed(rs_val_c) < $signed(op_b_c));
      default: alu_d = rs_val_c + op_b_c;
    endcase

    zero_d   = (alu_d == '0);
    target_d = i_PCplus4 + {i_signextImmediate[DATA_W-3:0], 2'b00};
    store_d  = rt_val_c;
    wr_d     = i_RegDst ? i_RegDst2 : i_RegDst1;

    // Flush turns the instruction into a bubble; data fields are don't-care
    mem_to_reg_d = i_MemtoReg & ~i_flush;
    mem_write_d  = i_MemWrite & ~i_flush;
    mem_read_d   = i_MemRead  & ~i_flush;
    branch_d     = i_Branch   & ~i_flush;
    reg_write_d  = i_RegWrite & ~i_flush;
  end

  // Flush overrides stall so a bubble can be injected into a held stage
  assign load_c = ~i_stall | i_flush;

  // EX/MEM register
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      mem_to_reg_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      branch_q     <= 1'b0;
      reg_write_q  <= 1'b0;
      zero_q       <= 1'b0;
      alu_q        <= '0;
      target_q     <= '0;
      store_q      <= '0;
      wr_q         <= '0;
    end else if (load_c) begin
      mem_to_reg_q <= mem_to_reg_d;
      mem_write_q  <= mem_write_d;
      mem_read_q   <= mem_read_d;
      branch_q     <= branch_d;
      reg_write_q  <= reg_write_d;
      zero_q       <= zero_d;
      alu_q        <= alu_d;
      target_q     <= target_d;
      store_q      <= store_d;
      wr_q         <= wr_d;
    end
  end

  assign o_MemtoReg     = mem_to_reg_q;
  assign o_MemWrite     = mem_write_q;
  assign o_MemRead      = mem_read_q;
  assign o_Branch       = branch_q;
  assign o_RegWrite     = reg_write_q;
  assign o_Zero         = zero_q;
  assign o_ALUResult    = alu_q;
  assign o_BranchTarget = target_q;
  assign o_StoreData    = store_q;
  assign o_WriteReg     = wr_q;

endmodule

// File: tb/tb_ex_stage_reg.sv
// Testbench for ex_stage_reg: directed and random stimulus scored against a
// behavioural model through an expected-value queue.
module tb_ex_stage_reg;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          i_clk, i_rstn, i_stall, i_flush;
  logic          i_MemtoReg, i_MemWrite, i_MemRead, i_Branch;
  logic          i_ALUSrc, i_RegDst, i_RegWrite;
  logic [1:0]    i_ALUOp;
  logic [DW-1:0] i_PCplus4, i_Rdata1, i_Rdata2, i_signextImmediate;
  logic [AW-1:0] i_Rs, i_RegDst1, i_RegDst2;
  logic          i_MemWb_RegWrite;
  logic [AW-1:0] i_MemWb_WriteReg;
  logic [DW-1:0] i_MemWb_Data;
  logic          o_MemtoReg, o_MemWrite, o_MemRead, o_Branch, o_RegWrite, o_Zero;
  logic [DW-1:0] o_ALUResult, o_BranchTarget, o_StoreData;
  logic [AW-1:0] o_WriteReg;

  ex_stage_reg #(.DATA_W(DW), .REG_AW(AW)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_stall(i_stall), .i_flush(i_flush),
    .i_MemtoReg(i_MemtoReg), .i_MemWrite(i_MemWrite), .i_MemRead(i_MemRead),
    .i_Branch(i_Branch), .i_ALUSrc(i_ALUSrc), .i_RegDst(i_RegDst),
    .i_RegWrite(i_RegWrite), .i_ALUOp(i_ALUOp), .i_PCplus4(i_PCplus4),
    .i_Rdata1(i_Rdata1), .i_Rdata2(i_Rdata2),
    .i_signextImmediate(i_signextImmediate), .i_Rs(i_Rs),
    .i_RegDst1(i_RegDst1), .i_RegDst2(i_RegDst2),
    .i_MemWb_RegWrite(i_MemWb_RegWrite), .i_MemWb_WriteReg(i_MemWb_WriteReg),
    .i_MemWb_Data(i_MemWb_Data),
    .o_MemtoReg(o_MemtoReg), .o_MemWrite(o_MemWrite), .o_MemRead(o_MemRead),
    .o_Branch(o_Branch), .o_RegWrite(o_RegWrite), .o_Zero(o_Zero),
    .o_ALUResult(o_ALUResult), .o_BranchTarget(o_BranchTarget),
    .o_StoreData(o_StoreData), .o_WriteReg(o_WriteReg)
  );

  typedef struct {
    logic          mtr, mw, mr, br, rw, zero;
    logic [DW-1:0] alu, bt, sd;
    logic [AW-1:0] wr;
    bit            dv;  // data fields meaningful (not a flushed bubble)
  } exp_t;

  exp_t m;          // model of the EX/MEM register contents
  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " MemtoReg"}, DW'(o_MemtoReg), '0);
    check({tag, " MemWrite"}, DW'(o_MemWrite), '0);
    check({tag, " MemRead"},  DW'(o_MemRead),  '0);
    check({tag, " Branch"},   DW'(o_Branch),   '0);
    check({tag, " RegWrite"}, DW'(o_RegWrite), '0);
    check({tag, " Zero"},     DW'(o_Zero),     '0);
    check({tag, " ALUResult"}, o_ALUResult,    '0);
    check({tag, " BranchTarget"}, o_BranchTarget, '0);
    check({tag, " StoreData"}, o_StoreData,    '0);
    check({tag, " WriteReg"}, DW'(o_WriteReg), '0);
  endtask

  function automatic exp_t zero_state();
    exp_t z;
    z.mtr = 0; z.mw = 0; z.mr = 0; z.br = 0; z.rw = 0; z.zero = 0;
    z.alu = '0; z.bt = '0; z.sd = '0; z.wr = '0; z.dv = 1;
    return z;
  endfunction

  function automatic logic [DW-1:0] fwd(input logic [AW-1:0] r, input logic [DW-1:0] v);
`ifdef FORWARDING_EN
    if (m.rw && m.wr != 0 && m.wr == r) return m.alu;
    if (i_MemWb_RegWrite && i_MemWb_WriteReg != 0 && i_MemWb_WriteReg == r) return i_MemWb_Data;
`endif
    return v;
  endfunction

  // Reference model: compute what the register should hold after the next edge
  task automatic push_expected();
    exp_t n;
    logic [DW-1:0] a, rt, b, r;
    if (i_stall && !i_flush) begin
      n = m;
    end else begin
      a  = fwd(i_Rs, i_Rdata1);
      rt = fwd(i_RegDst1, i_Rdata2);
      b  = i_ALUSrc ? i_signextImmediate : rt;
      r  = a + b;
      if (i_ALUOp == 2'b01) r = a - b;
      else if (i_ALUOp == 2'b10) begin
        case (i_signextImmediate[5:0])
          6'h22: r = a - b;
          6'h24: r = a & b;
          6'h25: r = a | b;
          6'h27: r = ~(a | b);
          6'h2a: r = ($signed(a) < $signed(b)) ? 1 : 0;
          default: r = a + b;
        endcase
      end
      n.alu  = r;
      n.zero = (r == 0);
      n.bt   = i_PCplus4 + (i_signextImmediate * 4);
      n.sd   = rt;
      n.wr   = i_RegDst ? i_RegDst2 : i_RegDst1;
      n.mtr  = i_MemtoReg & !i_flush;
      n.mw   = i_MemWrite & !i_flush;
      n.mr   = i_MemRead  & !i_flush;
      n.br   = i_Branch   & !i_flush;
      n.rw   = i_RegWrite & !i_flush;
      n.dv   = !i_flush;
    end
    q.push_back(n);
    m = n;
  endtask

  // Monitor: one registered result is presented after every edge
  always @(posedge i_clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("MemtoReg", DW'(o_MemtoReg), DW'(e.mtr));
      check("MemWrite", DW'(o_MemWrite), DW'(e.mw));
      check("MemRead",  DW'(o_MemRead),  DW'(e.mr));
      check("Branch",   DW'(o_Branch),   DW'(e.br));
      check("RegWrite", DW'(o_RegWrite), DW'(e.rw));
      if (e.dv) begin
        check("Zero",         DW'(o_Zero),     DW'(e.zero));
        check("ALUResult",    o_ALUResult,     e.alu);
        check("BranchTarget", o_BranchTarget,  e.bt);
        check("StoreData",    o_StoreData,     e.sd);
        check("WriteReg",     DW'(o_WriteReg), DW'(e.wr));
      end
    end
  end

  task automatic set_nop();
    i_stall = 0; i_flush = 0;
    i_MemtoReg = 0; i_MemWrite = 0; i_MemRead = 0; i_Branch = 0;
    i_ALUSrc = 0; i_RegDst = 0; i_RegWrite = 0; i_ALUOp = 2'b00;
    i_PCplus4 = '0; i_Rdata1 = '0; i_Rdata2 = '0; i_signextImmediate = '0;
    i_Rs = '0; i_RegDst1 = '0; i_RegDst2 = '0;
    i_MemWb_RegWrite = 0; i_MemWb_WriteReg = '0; i_MemWb_Data = '0;
  endtask

  task automatic set_random();
    logic [5:0] functs [7];
    functs[0] = 6'h20; functs[1] = 6'h22; functs[2] = 6'h24; functs[3] = 6'h25;
    functs[4] = 6'h27; functs[5] = 6'h2a; functs[6] = 6'($urandom);
    i_stall    = ($urandom_range(0, 5) == 0);
    i_flush    = ($urandom_range(0, 7) == 0);
    i_MemtoReg = 1'($urandom); i_MemWrite = 1'($urandom);
    i_MemRead  = 1'($urandom); i_Branch   = 1'($urandom);
    i_ALUSrc   = 1'($urandom); i_RegDst   = 1'($urandom);
    i_RegWrite = 1'($urandom); i_ALUOp    = 2'($urandom);
    i_PCplus4  = $urandom;
    i_Rdata1   = $urandom;
    i_Rdata2   = ($urandom_range(0, 3) == 0) ? i_Rdata1 : $urandom;
    i_signextImmediate = $urandom;
    i_signextImmediate[5:0] = functs[$urandom_range(0, 6)];
    i_Rs = AW'($urandom_range(0, 7)); i_RegDst1 = AW'($urandom_range(0, 7));
    i_RegDst2 = AW'($urandom_range(0, 7));
    i_MemWb_RegWrite = 1'($urandom);
    i_MemWb_WriteReg = AW'($urandom_range(0, 7));
    i_MemWb_Data = $urandom;
  endtask

  initial begin
    set_nop();
    i_rstn = 0;
    m = zero_state();
    @(posedge i_clk); #2;
    check_all_zero("reset");
    @(negedge i_clk);
    i_rstn = 1;

    // R-type sub, equal operands -> zero result into rd=9
    set_nop(); i_ALUOp = 2'b10; i_signextImmediate = 32'h22;
    i_Rdata1 = 5; i_Rdata2 = 5; i_RegDst = 1; i_RegDst2 = 9; push_expected();
    @(negedge i_clk);
    // lw address with negative offset
    set_nop(); i_ALUSrc = 1; i_Rdata1 = 32'h1000; i_signextImmediate = 32'hFFFF_FFFC;
    i_RegDst1 = 4; i_MemRead = 1; i_MemtoReg = 1; i_RegWrite = 1; push_expected();
    @(negedge i_clk);
    // backward branch target
    set_nop(); i_ALUOp = 2'b01; i_Branch = 1; i_PCplus4 = 32'h40;
    i_signextImmediate = 32'hFFFF_FFFF; push_expected();
    @(negedge i_clk);
    // signed slt: -1 < 1
    set_nop(); i_ALUOp = 2'b10; i_signextImmediate = 32'h2a;
    i_Rdata1 = 32'hFFFF_FFFF; i_Rdata2 = 1; push_expected();
    @(negedge i_clk);
    // load result 7, hold two cycles, then stall+flush
    set_nop(); i_Rdata1 = 3; i_Rdata2 = 4; i_RegWrite = 1; i_RegDst1 = 6; push_expected();
    for (int k = 0; k < 2; k++) begin
      @(negedge i_clk);
      set_random(); i_stall = 1; i_flush = 0; push_expected();
    end
    @(negedge i_clk);
    set_random(); i_stall = 1; i_flush = 1; push_expected();
    @(negedge i_clk);
    // back-to-back dependency on r3, then on r0
    for (int k = 0; k < 2; k++) begin
      set_nop(); i_ALUOp = 2'b10; i_signextImmediate = 32'h20;
      i_Rdata1 = 4; i_Rdata2 = 6; i_RegDst = 1; i_RegWrite = 1;
      i_RegDst2 = (k == 0) ? AW'(3) : AW'(0); push_expected();
      @(negedge i_clk);
      set_nop(); i_ALUOp = 2'b10; i_signextImmediate = 32'h20;
      i_Rs = (k == 0) ? AW'(3) : AW'(0); i_RegDst1 = i_Rs;
      i_RegDst = 1; i_RegDst2 = 5; i_RegWrite = 1; push_expected();
      @(negedge i_clk);
    end
    // asynchronous reset while stalled
    set_random(); i_stall = 1; i_flush = 0;
    i_rstn = 0;
    #1;
    check_all_zero("reset_mid");
    m = zero_state();
    @(negedge i_clk);
    i_rstn = 1;

    for (int k = 0; k < 400; k++) begin
      set_random(); push_expected();
      @(negedge i_clk);
    end
    set_nop(); i_stall = 1;
    @(negedge i_clk);
    @(negedge i_clk);
    check("queue_drained", DW'(q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
